// File: rtl/alu_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_req_arbiter
//  Purpose  : Shares one external combinational ALU between two requesters.
//             One operation is in flight at a time, sequenced IDLE -> EXEC ->
//             RESP, with round-robin arbitration when both ports request.
//             Operands and op code are registered toward the ALU; the ALU
//             result and Zero flag are registered per response port.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req<p>_valid/_ready         request handshake, port p = 0/1
//   req<p>_a/_b/_ctl            operands and ALU op code
//   rsp<p>_valid/_ready         response handshake
//   rsp<p>_result/_zero         registered ALU result and Zero flag
//   alu_src_a/_b, alu_ctl       registered operands/op code to the ALU
//   alu_result, alu_zero        combinational ALU outputs
// ============================================================================
module alu_req_arbiter #(
   parameter int WIDTH = 32,
   parameter int CTLW  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   // port 0
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [CTLW-1:0]  req0_ctl,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_result,
   output logic             rsp0_zero,
   // port 1
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [CTLW-1:0]  req1_ctl,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_result,
   output logic             rsp1_zero,
   // shared ALU
   output logic [WIDTH-1:0] alu_src_a,
   output logic [WIDTH-1:0] alu_src_b,
   output logic [CTLW-1:0]  alu_ctl,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic owner;        // port whose operation is in flight
   logic last_grant;   // port granted most recently
   logic grant;        // port selected in IDLE
   logic grant_vld;    // some port is being accepted this cycle
   logic rsp_hs;       // owner's response handshake this cycle

   // ------------------------------------------------------------------------
   // Next-state, arbitration and request-ready decode
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt  = state;
      grant      = 1'b0;
      grant_vld  = 1'b0;
      rsp_hs     = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state)
         IDLE: begin
            grant_vld = req0_valid | req1_valid;
            // On a tie the port that did not win last time goes next;
            // otherwise the single requesting port wins.
            grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
            req0_ready = grant_vld & ~grant;
            req1_ready = grant_vld &  grant;
            if (grant_vld) begin
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            state_nxt = RESP;
         end
         RESP: begin
            // Only the owner's consumer can complete the response.
            rsp_hs = owner ? rsp1_ready : rsp0_ready;
            if (rsp_hs) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State, operand and response registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         owner       <= 1'b0;
         last_grant  <= 1'b1;   // lets port 0 win the first tie
         alu_src_a   <= '0;
         alu_src_b   <= '0;
         alu_ctl     <= '0;
         rsp0_valid  <= 1'b0;
         rsp0_result <= '0;
         rsp0_zero   <= 1'b0;
         rsp1_valid  <= 1'b0;
         rsp1_result <= '0;
         rsp1_zero   <= 1'b0;
      end else begin
         state <= state_nxt;

         // Operands only change on acceptance so the ALU inputs stay put
         // through EXEC and keep their value afterwards.
         if (state == IDLE && grant_vld) begin
            alu_src_a  <= grant ? req1_a   : req0_a;
            alu_src_b  <= grant ? req1_b   : req0_b;
            alu_ctl    <= grant ? req1_ctl : req0_ctl;
            owner      <= grant;
            last_grant <= grant;
         end

         if (state == EXEC) begin
            if (owner) begin
               rsp1_result <= alu_result;
               rsp1_zero   <= alu_zero;
               rsp1_valid  <= 1'b1;
            end else begin
               rsp0_result <= alu_result;
               rsp0_zero   <= alu_zero;
               rsp0_valid  <= 1'b1;
            end
         end

         // Result/zero are left untouched when valid drops.
         if (state == RESP && rsp_hs) begin
            if (owner) begin
               rsp1_valid <= 1'b0;
            end else begin
               rsp0_valid <= 1'b0;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_req_arbiter
//  Purpose  : Self-checking bench for alu_req_arbiter. Supplies a
//             behavioural ALU, directed scenarios plus randomized traffic,
//             and a transaction-level reference model that predicts
//             readies, response timing, results and grant order.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_req_arbiter;

   localparam int WIDTH = 32;
   localparam int CTLW  = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
   logic             req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
   logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b, rsp0_result, rsp1_result;
   logic [CTLW-1:0]  req0_ctl, req1_ctl, alu_ctl;
   logic [WIDTH-1:0] alu_src_a, alu_src_b, alu_result;
   logic             alu_zero;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_req_arbiter #(.WIDTH(WIDTH), .CTLW(CTLW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
      .req0_b(req0_b), .req0_ctl(req0_ctl), .rsp0_valid(rsp0_valid),
      .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
      .req1_b(req1_b), .req1_ctl(req1_ctl), .rsp1_valid(rsp1_valid),
      .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctl(alu_ctl),
      .alu_result(alu_result), .alu_zero(alu_zero)
   );

   // Behavioural ALU: 0 ADD, 1 SUB, 2 AND, 3 SLT (signed), 10 BNE, else 0.
   function automatic logic [WIDTH-1:0] alu_f(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [CTLW-1:0]  c);
      case (c)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return ($signed(a) < $signed(b)) ? 1 : 0;
         4'd10:   return (a == b) ? 1 : 0;
         default: return '0;
      endcase
   endfunction

   assign alu_result = alu_f(alu_src_a, alu_src_b, alu_ctl);
   assign alu_zero   = (alu_result == '0);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model: one transaction outstanding; tracks what each port and
   // the ALU should show, and logs every grant.
   // ------------------------------------------------------------------------
   logic             m_pend  = 1'b0;   // a transaction is outstanding
   logic             m_exec  = 1'b0;   // accepted, result not yet visible
   logic             m_owner = 1'b0;
   logic             m_last  = 1'b1;
   logic [WIDTH-1:0] m_res   = '0;
   logic [WIDTH-1:0] hold_res0 = '0, hold_res1 = '0;
   logic             hold_z0 = 1'b0, hold_z1 = 1'b0;
   logic [WIDTH-1:0] hold_a = '0, hold_b = '0;
   logic [CTLW-1:0]  hold_ctl = '0;
   logic             anyv, g;
   int               grants[$];

   initial begin
      forever begin
         @(negedge clk or negedge rst_n);
         if (!rst_n) begin
            m_pend = 1'b0; m_exec = 1'b0; m_owner = 1'b0; m_last = 1'b1;
            hold_res0 = '0; hold_res1 = '0; hold_z0 = 1'b0; hold_z1 = 1'b0;
            hold_a = '0; hold_b = '0; hold_ctl = '0;
         end else begin
            anyv = req0_valid | req1_valid;
            g    = (req0_valid && req1_valid) ? !m_last : req1_valid;
            check("req0_ready", req0_ready, !m_pend && anyv && !g);
            check("req1_ready", req1_ready, !m_pend && anyv && g);
            check("rsp0_valid", rsp0_valid, m_pend && !m_exec && !m_owner);
            check("rsp1_valid", rsp1_valid, m_pend && !m_exec && m_owner);
            check("rsp0_result", rsp0_result, hold_res0);
            check("rsp0_zero", rsp0_zero, hold_z0);
            check("rsp1_result", rsp1_result, hold_res1);
            check("rsp1_zero", rsp1_zero, hold_z1);
            check("alu_src_a", alu_src_a, hold_a);
            check("alu_src_b", alu_src_b, hold_b);
            check("alu_ctl", alu_ctl, hold_ctl);
            // advance to what the next rising edge should produce
            if (!m_pend && anyv) begin
               hold_a   = g ? req1_a   : req0_a;
               hold_b   = g ? req1_b   : req0_b;
               hold_ctl = g ? req1_ctl : req0_ctl;
               m_res    = alu_f(hold_a, hold_b, hold_ctl);
               m_pend   = 1'b1; m_exec = 1'b1; m_owner = g; m_last = g;
               grants.push_back(int'(g));
            end else if (m_pend && m_exec) begin
               if (m_owner) begin hold_res1 = m_res; hold_z1 = (m_res == '0); end
               else         begin hold_res0 = m_res; hold_z0 = (m_res == '0); end
               m_exec = 1'b0;
            end else if (m_pend && (m_owner ? rsp1_ready : rsp0_ready)) begin
               m_pend = 1'b0;
            end
         end
      end
   end

   // Response consumers: random readiness unless forced.
   logic rr_force0 = 1'b0, rr_force1 = 1'b0, rr_val0 = 1'b0, rr_val1 = 1'b0;
   initial begin
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         rsp0_ready = rr_force0 ? rr_val0 : 1'($urandom_range(0, 1));
         rsp1_ready = rr_force1 ? rr_val1 : 1'($urandom_range(0, 1));
      end
   end

   // Present one request and hold it until accepted.
   task automatic send(input int p, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [CTLW-1:0] c);
      bit done = 0;
      @(posedge clk); #1;
      if (p == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctl = c; end
      else        begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctl = c; end
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if ((p == 0) ? req0_ready : req1_ready) done = 1;
      end
      if (!done) check("send_timeout", 0, 1);
      @(posedge clk); #1;
      if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk); #1;
         if (!m_pend) done = 1;
      end
      if (!done) check("idle_timeout", 0, 1);
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   logic [CTLW-1:0] ops[6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd10, 4'd15};

   initial begin
      rst_n = 1'b0;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctl = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctl = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); #2 rst_n = 1'b1;
      check("rst_rsp0_valid", rsp0_valid, 0);
      check("rst_rsp1_valid", rsp1_valid, 0);
      check("rst_alu_src_a", alu_src_a, 0);
      check("rst_rsp1_result", rsp1_result, 0);

      // 1: async reset while a response is pending
      rr_force0 = 1'b1; rr_val0 = 1'b0;
      send(0, 32'd9, 32'd1, 4'd0);
      for (int i = 0; i < 10 && !rsp0_valid; i++) @(negedge clk);
      check("t1_pending", rsp0_valid, 1);
      @(posedge clk); #3 rst_n = 1'b0;
      #1;
      check("t1_async_valid", rsp0_valid, 0);
      check("t1_async_result", rsp0_result, 0);
      check("t1_async_src_a", alu_src_a, 0);
      @(negedge clk); @(negedge clk); #2 rst_n = 1'b1;
      rr_force0 = 1'b0;
      send(0, 32'd2, 32'd3, 4'd0);
      wait_idle();
      check("t1_add_result", rsp0_result, 5);
      check("t1_add_zero", rsp0_zero, 0);

      // 2: single port SUB
      send(0, 32'd7, 32'd7, 4'd1);
      wait_idle();
      check("t2_sub_result", rsp0_result, 0);
      check("t2_sub_zero", rsp0_zero, 1);

      // 3: contention straight out of reset
      do_reset();
      grants.delete();
      fork
         send(0, 32'd1, 32'd1, 4'd0);
         send(1, 32'hFFFF_FFFF, 32'd0, 4'd3);
      join
      wait_idle();
      check("t3_ngrants", grants.size(), 2);
      if (grants.size() >= 2) begin
         check("t3_first", grants[0], 0);
         check("t3_second", grants[1], 1);
      end
      check("t3_rsp0", rsp0_result, 2);
      check("t3_rsp1", rsp1_result, 1);

      // 4: alternation with both ports busy
      grants.delete();
      fork
         begin repeat (3) send(0, $urandom, $urandom, ops[$urandom_range(0, 5)]); end
         begin repeat (3) send(1, $urandom, $urandom, ops[$urandom_range(0, 5)]); end
      join
      wait_idle();
      check("t4_ngrants", grants.size(), 6);
      if (grants.size() >= 6)
         for (int i = 0; i < 6; i++) check("t4_grant", grants[i], i % 2);

      // 5: response backpressure on port 1 while port 0 waits
      rr_force1 = 1'b1; rr_val1 = 1'b0;
      send(1, 32'd40, 32'd2, 4'd1);
      fork
         send(0, 32'd11, 32'd22, 4'd0);
         begin
            repeat (10) @(negedge clk);
            check("t5_held_valid", rsp1_valid, 1);
            check("t5_held_result", rsp1_result, 38);
            check("t5_req0_blocked", req0_ready, 0);
            rr_val1 = 1'b1;
         end
      join
      rr_force1 = 1'b0;
      wait_idle();
      check("t5_rsp0", rsp0_result, 33);

      // 6: op codes the block does not interpret
      send(1, 32'd5, 32'd9, 4'd15);
      wait_idle();
      check("t6_default_result", rsp1_result, 0);
      check("t6_default_zero", rsp1_zero, 1);
      send(1, 32'd4, 32'd4, 4'd10);
      wait_idle();
      check("t6_bne_result", rsp1_result, 1);

      // randomized traffic on both ports
      fork
         begin
            repeat (25) begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               send(0, $urandom, $urandom, ops[$urandom_range(0, 5)]);
            end
         end
         begin
            repeat (25) begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               send(1, $urandom, $urandom, ops[$urandom_range(0, 5)]);
            end
         end
      join
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
